// File: rtl/c_misalign.sv
// Halfword-parcel aligner between a word-aligned RV32C fetch and the decoder.
// Optional macro C_MISALIGN_FLUSH_NOP_EN squashes the redirect-cycle instruction to a NOP.
module c_misalign (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel_for_branch,
    input  logic [31:0] inst_in,
    output logic        stall_pc,
    output logic        pc_misaligned_o,
    output logic        misalign_fetch,
    output logic [31:0] inst_out
);

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {
        ALIGNED,
        UPPER,
        SPLIT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] hold_q, hold_d;
    logic        lo_is32, hi_is32;
    logic [31:0] aligned_inst;

    assign lo_is32      = (inst_in[1:0] == 2'b11);
    assign hi_is32      = (inst_in[17:16] == 2'b11);
    assign aligned_inst = lo_is32 ? inst_in : {16'h0, inst_in[15:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ALIGNED;
            hold_q  <= 16'h0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        hold_d          = hold_q;
        stall_pc        = 1'b0;
        pc_misaligned_o = 1'b0;
        misalign_fetch  = 1'b0;
        inst_out        = aligned_inst;

        if (reset) begin
            inst_out = NOP;
        end else if (sel_for_branch) begin
            // Redirect wins over everything; any half-consumed word is abandoned.
            state_d = ALIGNED;
            hold_d  = 16'h0;
`ifdef C_MISALIGN_FLUSH_NOP_EN
            inst_out = NOP;
`else
            inst_out = aligned_inst;
`endif
        end else begin
            case (state_q)
                ALIGNED: begin
                    if (lo_is32) begin
                        state_d = ALIGNED;
                    end else if (!hi_is32) begin
                        stall_pc = 1'b1;
                        state_d  = UPPER;
                    end else begin
                        hold_d  = inst_in[31:16];
                        state_d = SPLIT;
                    end
                end
                UPPER: begin
                    inst_out        = {16'h0, inst_in[31:16]};
                    pc_misaligned_o = 1'b1;
                    state_d         = ALIGNED;
                end
                SPLIT: begin
                    // Low half of the new word completes the instruction begun last cycle.
                    inst_out        = {inst_in[15:0], hold_q};
                    pc_misaligned_o = 1'b1;
                    misalign_fetch  = 1'b1;
                    if (!hi_is32) begin
                        stall_pc = 1'b1;
                        state_d  = UPPER;
                    end else begin
                        hold_d  = inst_in[31:16];
                        state_d = SPLIT;
                    end
                end
                default: begin
                    state_d = ALIGNED;
                    hold_d  = 16'h0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_c_misalign.sv
// Testbench for c_misalign: directed vector table plus randomized fetch stream
// checked against a halfword-stream reference model.
module tb_c_misalign;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel_for_branch = 1'b0;
    logic [31:0] inst_in = 32'h0;
    logic        stall_pc, pc_misaligned_o, misalign_fetch;
    logic [31:0] inst_out;

    int tests_run = 0;
    int tests_failed = 0;

    c_misalign dut (
        .clk(clk),
        .reset(reset),
        .sel_for_branch(sel_for_branch),
        .inst_in(inst_in),
        .stall_pc(stall_pc),
        .pc_misaligned_o(pc_misaligned_o),
        .misalign_fetch(misalign_fetch),
        .inst_out(inst_out)
    );

    always #5 clk = ~clk;

    // Reference model: halfwords left over from the previous word, and the
    // halfword offset at which the current word's next instruction begins.
    logic [15:0] m_pending[$];
    int          m_offset = 0;
    logic [15:0] n_pending[$];
    int          n_offset = 0;
    logic [31:0] e_out;
    logic        e_stall, e_pm, e_mf;

    function automatic logic [31:0] flush_value(input logic [31:0] w);
`ifdef C_MISALIGN_FLUSH_NOP_EN
        return NOP;
`else
        return (w[1:0] == 2'b11) ? w : {16'h0, w[15:0]};
`endif
    endfunction

    task automatic model_eval(input logic r, input logic br, input logic [31:0] w);
        logic [15:0] s[$];
        logic [15:0] last;
        int len, npend, left;
        e_stall = 1'b0; e_pm = 1'b0; e_mf = 1'b0;
        n_pending = {};
        n_offset = 0;
        if (r) begin
            e_out = NOP;
        end else if (br) begin
            e_out = flush_value(w);
        end else begin
            s = m_pending;
            npend = m_pending.size();
            if (m_offset == 0) s.push_back(w[15:0]);
            s.push_back(w[31:16]);
            len = (s[0][1:0] == 2'b11) ? 2 : 1;
            if (len > s.size()) len = s.size();
            e_out = (len == 2) ? {s[1], s[0]} : {16'h0, s[0]};
            e_pm = (npend > 0) || (m_offset == 2);
            e_mf = (npend > 0) && (len == 2);
            left = s.size() - len;
            if (left == 1) begin
                last = s[len];
                if (last[1:0] == 2'b11) n_pending.push_back(last);
                else begin
                    e_stall = 1'b1;
                    n_offset = 2;
                end
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Drive one cycle, check at the negedge, then let the model follow the clock edge.
    task automatic applyStimulus(input logic r, input logic br, input logic [31:0] w);
        reset = r;
        sel_for_branch = br;
        inst_in = w;
        model_eval(r, br, w);
        @(negedge clk);
    endtask

    task automatic commitModel();
        @(posedge clk);
        #1;
        m_pending = n_pending;
        m_offset = n_offset;
    endtask

    typedef struct {
        logic        r;
        logic        br;
        logic [31:0] w;
        logic [31:0] out;
        logic        stall;
        logic        pm;
        logic        mf;
    } vec_t;

    vec_t vecs[$];
    logic [31:0] word;
    logic        r, br;

    initial begin
        vecs.push_back('{1, 0, 32'h006fc104, NOP,          0, 0, 0});
        vecs.push_back('{0, 0, 32'h00a00093, 32'h00a00093, 0, 0, 0});
        vecs.push_back('{0, 0, 32'h006fc104, 32'h0000c104, 0, 0, 0});
        vecs.push_back('{0, 0, 32'h41040040, 32'h0040006f, 1, 1, 1});
        vecs.push_back('{0, 0, 32'h41040040, 32'h00004104, 0, 1, 0});
        vecs.push_back('{0, 0, 32'h41044104, 32'h00004104, 1, 0, 0});
        vecs.push_back('{0, 0, 32'h41044104, 32'h00004104, 0, 1, 0});
        vecs.push_back('{0, 0, 32'h006fc104, 32'h0000c104, 0, 0, 0});
        vecs.push_back('{0, 0, 32'h00ef0040, 32'h0040006f, 0, 1, 1});
        vecs.push_back('{0, 1, 32'h0863c104, flush_value(32'h0863c104), 0, 0, 0});
        vecs.push_back('{0, 0, 32'h0863c104, 32'h0000c104, 0, 0, 0});
        vecs.push_back('{0, 0, 32'h00a00093, 32'h00930863, 1, 1, 1});
        vecs.push_back('{0, 0, 32'h00a00093, 32'h000000a0, 0, 1, 0});
        vecs.push_back('{0, 0, 32'h006fc104, 32'h0000c104, 0, 0, 0});
        vecs.push_back('{1, 0, 32'h41040040, NOP,          0, 0, 0});
        vecs.push_back('{0, 0, 32'h41040040, 32'h00000040, 1, 0, 0});
        vecs.push_back('{0, 1, 32'h00a00093, flush_value(32'h00a00093), 0, 0, 0});
        vecs.push_back('{0, 0, 32'h00a00093, 32'h00a00093, 0, 0, 0});

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].r, vecs[i].br, vecs[i].w);
            checkOutput($sformatf("vec%0d inst_out", i), inst_out, vecs[i].out);
            checkOutput($sformatf("vec%0d stall_pc", i), {31'h0, stall_pc}, {31'h0, vecs[i].stall});
            checkOutput($sformatf("vec%0d pc_misaligned_o", i), {31'h0, pc_misaligned_o}, {31'h0, vecs[i].pm});
            checkOutput($sformatf("vec%0d misalign_fetch", i), {31'h0, misalign_fetch}, {31'h0, vecs[i].mf});
            commitModel();
        end

        // Random fetch stream; a stalled PC re-presents the same word.
        word = 32'h0;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 39) == 0);
            br = ($urandom_range(0, 7) == 0);
            if (r || br || !e_stall) begin
                word = $urandom;
                if ($urandom_range(0, 1) == 1) word[1:0] = 2'b11;
                if ($urandom_range(0, 1) == 1) word[17:16] = 2'b11;
            end
            applyStimulus(r, br, word);
            checkOutput($sformatf("rnd%0d inst_out", i), inst_out, e_out);
            checkOutput($sformatf("rnd%0d stall_pc", i), {31'h0, stall_pc}, {31'h0, e_stall});
            checkOutput($sformatf("rnd%0d pc_misaligned_o", i), {31'h0, pc_misaligned_o}, {31'h0, e_pm});
            checkOutput($sformatf("rnd%0d misalign_fetch", i), {31'h0, misalign_fetch}, {31'h0, e_mf});
            commitModel();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
